// File: rtl/rst_seq_ctrl_pkg.sv
// Shared types and constants for the reset sequencer (package rst_seq_pkg).
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_e;

  localparam int CAUSE_W    = 5;
  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_WDOG = 1;
  localparam int CAUSE_NDM  = 2;
  localparam int CAUSE_PROG = 3;
  localparam int CAUSE_SW   = 4;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases them in index order.
// Optional macro RST_SEQ_DBG_KEEP_EN keeps domain 0 out of ndm-only resets.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM    = 3,
  parameter int CNT_W      = 8,
  parameter int MIN_ASSERT = 16,
  parameter int STAGE_GAP  = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ndm_req_i,
  input  logic               prog_rst_ni,
  input  logic               wdog_req_i,
  input  logic               sw_req_i,
  input  logic               cause_clr_i,
  output logic [NUM_DOM-1:0] rst_no,
  output logic               done_o,
  output logic [4:0]         cause_o
);

  localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DOM - 1);
  localparam logic [NUM_DOM-1:0] DOM0_MASK = NUM_DOM'(1);

  rst_seq_state_e       state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [NUM_DOM-1:0]   rst_q;
  logic                 done_q;
  logic [CAUSE_W-1:0]   cause_q;
  logic                 keep_q;

  logic [CAUSE_W-1:0]   req_vec;
  logic                 req_any;
  logic                 hard_req;
  logic                 keep_d;

  always_comb begin
    req_vec             = '0;
    req_vec[CAUSE_SW]   = sw_req_i;
    req_vec[CAUSE_PROG] = ~prog_rst_ni;
    req_vec[CAUSE_NDM]  = ndm_req_i;
    req_vec[CAUSE_WDOG] = wdog_req_i;
    req_any             = |req_vec;
    hard_req            = sw_req_i | ~prog_rst_ni | wdog_req_i;
`ifdef RST_SEQ_DBG_KEEP_EN
    // Domain 0 may only be spared if it is already out of reset.
    keep_d = (NUM_DOM > 1) && ndm_req_i && !hard_req && rst_q[0];
`else
    keep_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_W'(1);
      keep_q  <= 1'b0;
    end else begin
      if (cause_clr_i) cause_q <= '0;
      case (state_q)
        HOLD: begin
          done_q <= 1'b0;
          if (keep_q && hard_req) begin
            keep_q <= 1'b0;
            rst_q  <= '0;
          end
          if (cnt_q == HOLD_LAST) begin
            if (!req_any) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
              idx_q   <= keep_q ? IDX_W'(1) : '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE, RUN: begin
          if (req_any) begin
            // Later assignment overrides the clear: new bits survive a same-cycle clear.
            cause_q <= cause_clr_i ? req_vec : (cause_q | req_vec);
            state_q <= HOLD;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            keep_q  <= keep_d;
            rst_q   <= keep_d ? (rst_q & DOM0_MASK) : '0;
          end else if (state_q == RUN) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            rst_q[idx_q] <= 1'b1;
            cnt_q        <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              done_q  <= 1'b1;
              keep_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= HOLD;
          cnt_q   <= '0;
          rst_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rst_no  = rst_q;
  assign done_o  = done_q;
  assign cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with MIN_ASSERT=4, STAGE_GAP=2, NUM_DOM=3.
module tb_rst_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ndm_req_i = 1'b0;
  logic       prog_rst_ni = 1'b1;
  logic       wdog_req_i = 1'b0;
  logic       sw_req_i = 1'b0;
  logic       cause_clr_i = 1'b0;
  logic [2:0] rst_no;
  logic       done_o;
  logic [4:0] cause_o;

  int checks = 0;
  int failures = 0;

  rst_seq_ctrl #(
    .NUM_DOM(3), .CNT_W(8), .MIN_ASSERT(4), .STAGE_GAP(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ndm_req_i(ndm_req_i), .prog_rst_ni(prog_rst_ni),
    .wdog_req_i(wdog_req_i), .sw_req_i(sw_req_i), .cause_clr_i(cause_clr_i),
    .rst_no(rst_no), .done_o(done_o), .cause_o(cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       ndm;
    logic       prog_n;
    logic       wdog;
    logic       sw;
    logic       clr;
    logic [2:0] exp_rst;
    logic       exp_done;
    logic [4:0] exp_cause;
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [2:0] er, input logic ed, input logic [4:0] ec);
    checks += 3;
    if (rst_no !== er) begin
      failures++;
      $display("FAIL %s rst_no got=%b exp=%b", name, rst_no, er);
    end
    if (done_o !== ed) begin
      failures++;
      $display("FAIL %s done_o got=%b exp=%b", name, done_o, ed);
    end
    if (cause_o !== ec) begin
      failures++;
      $display("FAIL %s cause_o got=%b exp=%b", name, cause_o, ec);
    end
    $display("%t %s rst_no=%b done=%b cause=%b", $time, name, rst_no, done_o, cause_o);
  endtask

  task automatic step(input logic ndm, input logic prog_n, input logic wdog, input logic sw, input logic clr);
    ndm_req_i = ndm; prog_rst_ni = prog_n; wdog_req_i = wdog; sw_req_i = sw; cause_clr_i = clr;
    @(posedge clk_i);
    #1;
    ndm_req_i = 1'b0; prog_rst_ni = 1'b1; wdog_req_i = 1'b0; sw_req_i = 1'b0; cause_clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_o !== 1'b1 && n < 60) begin
      idle(1);
      n++;
    end
    checks++;
    if (done_o !== 1'b1) begin
      failures++;
      $display("FAIL %s wait_done timeout got=%b exp=1", name, done_o);
    end
  endtask

  initial begin
    // POR release sequence then a one-cycle watchdog pulse from RUN.
    for (int i = 0; i < 3; i++)  vecs[i] = '{0, 1, 0, 0, 0, 3'b000, 0, 5'b00001};
    vecs[3]  = '{0, 1, 0, 0, 0, 3'b000, 0, 5'b00001};
    vecs[4]  = '{0, 1, 0, 0, 0, 3'b000, 0, 5'b00001};
    vecs[5]  = '{0, 1, 0, 0, 0, 3'b001, 0, 5'b00001};
    vecs[6]  = '{0, 1, 0, 0, 0, 3'b001, 0, 5'b00001};
    vecs[7]  = '{0, 1, 0, 0, 0, 3'b011, 0, 5'b00001};
    vecs[8]  = '{0, 1, 0, 0, 0, 3'b011, 0, 5'b00001};
    vecs[9]  = '{0, 1, 0, 0, 0, 3'b111, 1, 5'b00001};
    vecs[10] = '{0, 1, 0, 0, 0, 3'b111, 1, 5'b00001};
    vecs[11] = '{0, 1, 1, 0, 0, 3'b000, 0, 5'b00011};
    for (int i = 12; i < 17; i++) vecs[i] = '{0, 1, 0, 0, 0, 3'b000, 0, 5'b00011};
    vecs[17] = '{0, 1, 0, 0, 0, 3'b001, 0, 5'b00011};
    vecs[18] = '{0, 1, 0, 0, 0, 3'b001, 0, 5'b00011};
    vecs[19] = '{0, 1, 0, 0, 0, 3'b011, 0, 5'b00011};
    vecs[20] = '{0, 1, 0, 0, 0, 3'b011, 0, 5'b00011};
    vecs[21] = '{0, 1, 0, 0, 0, 3'b111, 1, 5'b00011};
    vecs[22] = '{0, 1, 0, 0, 1, 3'b111, 1, 5'b00000};

    repeat (3) @(posedge clk_i);
    #1;
    check("reset", 3'b000, 1'b0, 5'b00001);
    rst_ni = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].ndm, vecs[i].prog_n, vecs[i].wdog, vecs[i].sw, vecs[i].clr);
      check($sformatf("vec%0d", i + 1), vecs[i].exp_rst, vecs[i].exp_done, vecs[i].exp_cause);
    end

    // Persistent programmer reset extends HOLD; release starts one edge after it drops.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prog_hold", 3'b000, 1'b0, 5'b01000);
    idle(2);
    check("prog_rel_gap", 3'b000, 1'b0, 5'b01000);
    idle(1);
    check("prog_rel_dom0", 3'b001, 1'b0, 5'b01000);
    wait_done("prog");
    check("prog_done", 3'b111, 1'b1, 5'b01000);

    // ndm request during RELEASE after domain 0 is out.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("sw_clr", 3'b000, 1'b0, 5'b10000);
    idle(6);
    check("abort_pre", 3'b001, 1'b0, 5'b10000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef RST_SEQ_DBG_KEEP_EN
    check("ndm_abort", 3'b001, 1'b0, 5'b10100);
    idle(3);
    check("ndm_hold", 3'b001, 1'b0, 5'b10100);
`else
    check("ndm_abort", 3'b000, 1'b0, 5'b10100);
    idle(3);
    check("ndm_hold", 3'b000, 1'b0, 5'b10100);
`endif
    wait_done("ndm");
    check("ndm_done", 3'b111, 1'b1, 5'b10100);

    // Simultaneous sw+ndm with a same-cycle clear records only the new bits.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("prog_wdog_clr", 3'b000, 1'b0, 5'b01010);
    wait_done("prog_wdog");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
`ifdef RST_SEQ_DBG_KEEP_EN
    check("sw_ndm_clr", 3'b000, 1'b0, 5'b10100);
`else
    check("sw_ndm_clr", 3'b000, 1'b0, 5'b10100);
`endif
    wait_done("sw_ndm");

    // Asynchronous power-on reset mid-RELEASE with idx=1.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(7);
    check("pre_por", 3'b001, 1'b0, 5'b10110);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_por", 3'b000, 1'b0, 5'b00001);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(9);
    check("por2_pre_done", 3'b011, 1'b0, 5'b00001);
    idle(1);
    check("por2_done", 3'b111, 1'b1, 5'b00001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
